// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: ALU opcodes and the decoded control bundle
// used by decode, the ID/EX register and execute.
package rv32i_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // True when a source operand that is actually read matches the destination.
  function automatic logic reads_reg(input logic                 uses,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection between the instruction in decode
// and a load sitting in the ID/EX register.
module hazard_detect
  import rv32i_pkg::*;
(
  input  logic                 idex_valid,
  input  logic                 idex_mem_read,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 id_valid,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  output logic                 load_use
);

  // x0 is never written, so a load to x0 can never create a dependency.
  assign load_use = idex_valid && idex_mem_read && (idex_rd != '0) && id_valid &&
                    (reads_reg(id_uses_rs1, id_rs1, idex_rd) ||
                     reads_reg(id_uses_rs2, id_rs2, idex_rd));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, back-pressure hold, load-use bubble
// insertion and bubble/stall performance counters.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  ctrl_t                id_ctrl,
  input  logic                 ex_stall,
  input  logic                 flush,
  output logic                 idex_valid,
  output logic [XLEN-1:0]      idex_pc,
  output logic [XLEN-1:0]      idex_rs1_data,
  output logic [XLEN-1:0]      idex_rs2_data,
  output logic [XLEN-1:0]      idex_imm,
  output logic [REG_IDX_W-1:0] idex_rs1,
  output logic [REG_IDX_W-1:0] idex_rs2,
  output logic [REG_IDX_W-1:0] idex_rd,
  output ctrl_t                idex_ctrl,
  output logic                 ifid_hold,
  output logic [31:0]          bubble_count,
  output logic [31:0]          stall_count
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } action_t;

  action_t     action;
  logic        load_use;
  logic [31:0] bubble_q;
  logic [31:0] stall_q;

  hazard_detect u_hazard_detect (
    .idex_valid    (idex_valid),
    .idex_mem_read (idex_ctrl.mem_read),
    .idex_rd       (idex_rd),
    .id_valid      (id_valid),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .load_use      (load_use)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives action; no latch is inferred.
    action = ACT_ADVANCE;
    if (flush)         action = ACT_FLUSH;
    else if (ex_stall) action = ACT_HOLD;
    else if (load_use) action = ACT_BUBBLE;
  end

  // Gated by rst_n so the front end is never held while the pipe is in reset.
  assign ifid_hold = rst_n && ((action == ACT_HOLD) || (action == ACT_BUBBLE));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid    <= 1'b0;
      idex_ctrl     <= CTRL_NOP;
      idex_pc       <= '0;
      idex_rs1_data <= '0;
      idex_rs2_data <= '0;
      idex_imm      <= '0;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_rd       <= '0;
    end else begin
      case (action)
        ACT_FLUSH, ACT_BUBBLE: begin
          // A bubble carries no payload, so stale operands never reach forwarding.
          idex_valid    <= 1'b0;
          idex_ctrl     <= CTRL_NOP;
          idex_pc       <= '0;
          idex_rs1_data <= '0;
          idex_rs2_data <= '0;
          idex_imm      <= '0;
          idex_rs1      <= '0;
          idex_rs2      <= '0;
          idex_rd       <= '0;
        end
        ACT_HOLD: begin
        end
        default: begin
          idex_valid    <= id_valid;
          idex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
          idex_pc       <= id_pc;
          idex_rs1_data <= id_rs1_data;
          idex_rs2_data <= id_rs2_data;
          idex_imm      <= id_imm;
          idex_rs1      <= id_rs1;
          idex_rs2      <= id_rs2;
          idex_rd       <= id_rd;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      if (action == ACT_BUBBLE) bubble_q <= bubble_q + 32'd1;
      if (action == ACT_HOLD)   stall_q  <= stall_q + 32'd1;
    end
  end

  assign bubble_count = bubble_q;
  assign stall_count  = stall_q;

endmodule
